// File: rtl/fir_coeff_reloader.sv
// Coefficient bank plus reload transmitter feeding the FIR core's reload and config channels.
// Optional stall watchdog is enabled by defining FIR_RELOAD_TIMEOUT_EN.
module fir_coeff_reloader #(
  parameter int NUM_TAPS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                 clkfir,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic signed [15:0]   wr_data,
  input  logic                 commit,
  output logic                 reload_valid,
  input  logic                 reload_ready,
  output logic                 reload_last,
  output logic signed [15:0]   reload_coeff,
  output logic                 config_valid,
  input  logic                 config_ready,
  input  logic                 tlast_missing,
  input  logic                 tlast_unexpected,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           error
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    CONFIG,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_TAPS - 1);

  state_t             state_q;
  logic [ADDR_W-1:0]  beat_q;
  logic [ADDR_W-1:0]  beat_d;
  logic               reloadValid_q;
  logic               reloadLast_q;
  logic signed [15:0] reloadCoeff_q;
  logic               configValid_q;
  logic               busy_q;
  logic               done_q;
  logic [2:0]         error_q;
  logic [2:0]         error_d;

  logic signed [15:0] bank_q [NUM_TAPS];

  logic bankWe;
  logic commitAccept;
  logic reloadFire;
  logic timeoutHit;

  assign commitAccept = (state_q == IDLE) && commit;
  assign bankWe       = wr_en && (state_q == IDLE) && (32'(wr_addr) < NUM_TAPS);
  assign reloadFire   = reloadValid_q && reload_ready;
  assign beat_d       = beat_q + ADDR_W'(1);

`ifdef FIR_RELOAD_TIMEOUT_EN
  logic [9:0] wdog_q;
  logic       stalled;

  // Watchdog counts consecutive valid-without-ready cycles; the 1024th aborts.
  assign stalled    = (reloadValid_q && !reload_ready) || (configValid_q && !config_ready);
  assign timeoutHit = stalled && (wdog_q == 10'h3FF);

  always_ff @(posedge clkfir or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (stalled && !timeoutHit) begin
      wdog_q <= wdog_q + 10'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Event pulses set flags in any state; an accepted commit clears them first.
  assign error_d = (commitAccept ? 3'b000 : error_q)
                 | {timeoutHit, tlast_unexpected, tlast_missing};

  always_ff @(posedge clkfir) begin
    if (bankWe) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clkfir or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      reloadValid_q <= 1'b0;
      reloadLast_q  <= 1'b0;
      reloadCoeff_q <= '0;
      configValid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= error_d;
      case (state_q)
        IDLE: begin
          if (commit) begin
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          reloadCoeff_q <= bank_q[0];
          reloadLast_q  <= 1'b0;
          reloadValid_q <= 1'b1;
          state_q       <= STREAM;
        end
        STREAM: begin
          if (timeoutHit) begin
            reloadValid_q <= 1'b0;
            reloadLast_q  <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (reloadFire) begin
            if (beat_q == LAST_BEAT) begin
              reloadValid_q <= 1'b0;
              reloadLast_q  <= 1'b0;
              configValid_q <= 1'b1;
              state_q       <= CONFIG;
            end else begin
              // Next coefficient is loaded on the accepting edge so beats run back to back.
              beat_q        <= beat_d;
              reloadCoeff_q <= bank_q[beat_d];
              reloadLast_q  <= (beat_d == LAST_BEAT);
            end
          end
        end
        CONFIG: begin
          if (timeoutHit) begin
            configValid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (config_ready) begin
            configValid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          reloadValid_q <= 1'b0;
          reloadLast_q  <= 1'b0;
          configValid_q <= 1'b0;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign reload_valid = reloadValid_q;
  assign reload_last  = reloadLast_q;
  assign reload_coeff = reloadCoeff_q;
  assign config_valid = configValid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fir_coeff_reloader.sv
// Self-checking bench for fir_coeff_reloader against an array/queue model of the coefficient bank.
// The timeout scenario is exercised only when FIR_RELOAD_TIMEOUT_EN is defined.
module tb_fir_coeff_reloader;

  localparam int NUM_TAPS = 32;
  localparam int ADDR_W   = 5;

  logic              clkfir = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [15:0]       wr_data = '0;
  logic              commit = 1'b0;
  logic              reload_ready = 1'b0;
  logic              config_ready = 1'b0;
  logic              tlast_missing = 1'b0;
  logic              tlast_unexpected = 1'b0;
  logic              reload_valid;
  logic              reload_last;
  logic [15:0]       reload_coeff;
  logic              config_valid;
  logic              busy;
  logic              done;
  logic [2:0]        error;

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [15:0] modelBank [NUM_TAPS];
  logic [2:0]  modelError = 3'b000;
  int          cyc;

  fir_coeff_reloader #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W)) dut (
    .clkfir(clkfir),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .reload_valid(reload_valid),
    .reload_ready(reload_ready),
    .reload_last(reload_last),
    .reload_coeff(reload_coeff),
    .config_valid(config_valid),
    .config_ready(config_ready),
    .tlast_missing(tlast_missing),
    .tlast_unexpected(tlast_unexpected),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clkfir = ~clkfir;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeCoeff(input int addr, input logic [15:0] data);
    @(negedge clkfir);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = data;
    modelBank[addr] = data;
    @(negedge clkfir);
    wr_en = 1'b0;
  endtask

  function automatic logic pickReady(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return c[0];
    return 1'($urandom_range(0, 1));
  endfunction

  // One full reload: every presented beat must equal the model bank entry at the
  // number of beats accepted so far, which also catches repeats, drops and unstable stalls.
  task automatic applyStimulus(input int readyMode, input int cfgMode, input bit busyNoise,
                               input bit injectUnexpected, input bit writeWithCommit,
                               output int cycles);
    int beatIdx;
    bit injected;
    beatIdx  = 0;
    injected = 0;
    @(negedge clkfir);
    commit = 1'b1;
    if (writeWithCommit) begin
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = 16'($urandom);
      modelBank[0] = wr_data;
    end
    modelError = 3'b000;
    @(negedge clkfir);
    commit = 1'b0;
    wr_en  = 1'b0;
    cycles = 1;
    checkOutput("busy after commit", {31'd0, busy}, 32'd1);
    checkOutput("valid during fetch", {31'd0, reload_valid}, 32'd0);
    checkOutput("error cleared by commit", {29'd0, error}, {29'd0, modelError});
    while (done !== 1'b1 && cycles < 5000) begin
      tlast_unexpected = 1'b0;
      wr_en  = 1'b0;
      commit = 1'b0;
      if (reload_valid === 1'b1) begin
        if (beatIdx < NUM_TAPS) begin
          checkOutput("beat last/coeff", {15'd0, reload_last, reload_coeff},
                      {15'd0, (beatIdx == NUM_TAPS - 1), modelBank[beatIdx]});
        end else begin
          checkOutput("no extra beats", beatIdx, NUM_TAPS - 1);
        end
      end
      reload_ready = pickReady(readyMode, cycles);
      if (reload_valid === 1'b1 && reload_ready) beatIdx++;
      if (config_valid === 1'b1) begin
        checkOutput("config after all beats", beatIdx, NUM_TAPS);
      end
      config_ready = pickReady(cfgMode, cycles);
      if (injectUnexpected && !injected && reload_valid === 1'b1 && beatIdx == 7) begin
        tlast_unexpected = 1'b1;
        modelError[1]    = 1'b1;
        injected         = 1;
      end
      if (busyNoise && busy === 1'b1) begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(5);
        wr_data = 16'h7FFF;
        commit  = 1'($urandom_range(0, 1));
      end
      @(negedge clkfir);
      cycles++;
    end
    tlast_unexpected = 1'b0;
    wr_en  = 1'b0;
    commit = 1'b0;
    checkOutput("done reached", {31'd0, done}, 32'd1);
    checkOutput("busy low with done", {31'd0, busy}, 32'd0);
    checkOutput("all beats delivered", beatIdx, NUM_TAPS);
    checkOutput("error flags at done", {29'd0, error}, {29'd0, modelError});
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clkfir);
    checkOutput("reset reload_valid", {31'd0, reload_valid}, 32'd0);
    checkOutput("reset reload_last", {31'd0, reload_last}, 32'd0);
    checkOutput("reset config_valid", {31'd0, config_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset error", {29'd0, error}, 32'd0);
    checkOutput("reset coeff", {16'd0, reload_coeff}, 32'd0);
    reset = 1'b0;

    $display("[TB] write ramp and stream with ready high");
    for (int i = 0; i < NUM_TAPS; i++) writeCoeff(i, 16'(16'h0100 + i));
    applyStimulus(0, 0, 0, 0, 0, cyc);
    checkOutput("done latency from commit", cyc, 35);
    @(negedge clkfir);
    checkOutput("done is one cycle", {31'd0, done}, 32'd0);

    $display("[TB] toggled backpressure on both channels");
    applyStimulus(1, 1, 0, 0, 0, cyc);

    $display("[TB] tlast_missing while idle");
    @(negedge clkfir);
    tlast_missing = 1'b1;
    modelError[0] = 1'b1;
    @(negedge clkfir);
    tlast_missing = 1'b0;
    checkOutput("error from idle pulse", {29'd0, error}, {29'd0, modelError});

    $display("[TB] writes and commits while busy");
    applyStimulus(2, 2, 1, 0, 0, cyc);
    applyStimulus(2, 0, 0, 0, 0, cyc);

    $display("[TB] write coinciding with commit");
    applyStimulus(0, 2, 0, 0, 1, cyc);

    $display("[TB] tlast_unexpected during stream");
    applyStimulus(1, 0, 0, 1, 0, cyc);
    repeat (3) @(negedge clkfir);
    checkOutput("error sticky after done", {29'd0, error}, 32'd2);
    applyStimulus(0, 0, 0, 0, 0, cyc);

    $display("[TB] random bank and random handshakes");
    for (int i = 0; i < NUM_TAPS; i++) writeCoeff(i, 16'($urandom));
    for (int r = 0; r < 3; r++) applyStimulus(2, 2, 0, 0, 0, cyc);

    $display("[TB] reset in the middle of the stream");
    @(negedge clkfir);
    commit = 1'b1;
    reload_ready = 1'b1;
    config_ready = 1'b1;
    @(negedge clkfir);
    commit = 1'b0;
    repeat (11) @(negedge clkfir);
    checkOutput("beat 10 before reset", {16'd0, reload_coeff}, {16'd0, modelBank[10]});
    #2 reset = 1'b1;
    modelError = 3'b000;
    #1;
    checkOutput("async reset valid", {31'd0, reload_valid}, 32'd0);
    checkOutput("async reset last", {31'd0, reload_last}, 32'd0);
    checkOutput("async reset config", {31'd0, config_valid}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    @(negedge clkfir);
    reset = 1'b0;
    applyStimulus(2, 0, 0, 0, 0, cyc);

`ifdef FIR_RELOAD_TIMEOUT_EN
    begin
      int stallCycles;
      int doneSeen;
      $display("[TB] watchdog timeout");
      stallCycles = 0;
      doneSeen    = 0;
      @(negedge clkfir);
      commit = 1'b1;
      reload_ready = 1'b1;
      modelError = 3'b000;
      @(negedge clkfir);
      commit = 1'b0;
      repeat (4) @(negedge clkfir);
      checkOutput("beat 3 presented", {16'd0, reload_coeff}, {16'd0, modelBank[3]});
      reload_ready = 1'b0;
      while (reload_valid === 1'b1 && stallCycles < 1100) begin
        if (done === 1'b1) doneSeen++;
        stallCycles++;
        @(negedge clkfir);
      end
      modelError[2] = 1'b1;
      checkOutput("stall cycles before abort", stallCycles, 1024);
      checkOutput("valid dropped on timeout", {31'd0, reload_valid}, 32'd0);
      checkOutput("busy low on timeout", {31'd0, busy}, 32'd0);
      checkOutput("error on timeout", {29'd0, error}, {29'd0, modelError});
      repeat (2) begin
        if (done === 1'b1) doneSeen++;
        @(negedge clkfir);
      end
      checkOutput("no done on timeout", doneSeen, 0);
      reload_ready = 1'b1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
